chess_clock_ctrl: RTL and testbench

//  Game controller for the chess clock. It holds both players' remaining times as BCD mm:ss and runs the turn/pause/flag state machine.
//  It decodes all eight digits into 7-segment codes and drives them onto the seg1..seg8 inputs of Seven_seg_driver.

---
 rtl/chess_clock_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_chess_clock_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_ctrl.sv
// Chess clock game controller: holds both players' BCD mm:ss times, runs the
// turn/pause/flag state machine and drives eight registered 7-segment codes.
module chess_clock_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned INIT_MIN      = 5,
    parameter int unsigned INC_SEC       = 0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       CE,
    input  logic       BTN_P1,
    input  logic       BTN_P2,
    input  logic       BTN_START,
    input  logic       BTN_NEW,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [6:0] seg5,
    output logic [6:0] seg6,
    output logic [6:0] seg7,
    output logic [6:0] seg8,
    output logic       active_p1,
    output logic       active_p2,
    output logic       paused,
    output logic       flag_p1,
    output logic       flag_p2
);

    localparam int unsigned CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned HALF = TICKS_PER_SEC / 2;
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
    localparam logic [15:0]   INIT_TIME  = {4'(INIT_MIN / 10), 4'(INIT_MIN % 10), 8'h00};
    localparam logic [3:0]    INC_TENS   = 4'(INC_SEC / 10);
    localparam logic [3:0]    INC_ONES   = 4'(INC_SEC % 10);
    localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

    typedef enum logic [2:0] {
        ST_READY,
        ST_RUN1,
        ST_RUN2,
        ST_PAUSE1,
        ST_PAUSE2,
        ST_FLAG
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   t1_q, t1_d, t2_q, t2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          who_q, who_d;
    logic [15:0]   run_t, dec_t, new_t;
    logic          expired, turn_btn;
    logic          blank1, blank2;
    logic [6:0]    seg_d [8];

    // One-second countdown with borrow across s1 -> s10 -> m1 -> m10.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    // Fischer increment with carry, saturating at 99:59.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [4:0] s1, s10, m1, m10;
        s1  = {1'b0, t[3:0]} + {1'b0, INC_ONES};
        s10 = {1'b0, t[7:4]} + {1'b0, INC_TENS};
        m1  = {1'b0, t[11:8]};
        m10 = {1'b0, t[15:12]};
        if (s1 > 5'd9) begin
            s1  = s1 - 5'd10;
            s10 = s10 + 5'd1;
        end
        if (s10 > 5'd5) begin
            s10 = s10 - 5'd6;
            m1  = m1 + 5'd1;
        end
        if (m1 > 5'd9) begin
            m1  = m1 - 5'd10;
            m10 = m10 + 5'd1;
        end
        if (m10 > 5'd9) begin
            return 16'h9959;
        end
        return {m10[3:0], m1[3:0], s10[3:0], s1[3:0]};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= ST_READY;
            t1_q      <= INIT_TIME;
            t2_q      <= INIT_TIME;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            who_q     <= 1'b0;
            active_p1 <= 1'b0;
            active_p2 <= 1'b0;
            paused    <= 1'b0;
            flag_p1   <= 1'b0;
            flag_p2   <= 1'b0;
            seg1      <= SEG_BLANK;
            seg2      <= SEG_BLANK;
            seg3      <= SEG_BLANK;
            seg4      <= SEG_BLANK;
            seg5      <= SEG_BLANK;
            seg6      <= SEG_BLANK;
            seg7      <= SEG_BLANK;
            seg8      <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            who_q     <= who_d;
            active_p1 <= (state_d == ST_RUN1);
            active_p2 <= (state_d == ST_RUN2);
            paused    <= (state_d == ST_PAUSE1) || (state_d == ST_PAUSE2);
            flag_p1   <= (state_d == ST_FLAG) && !who_d;
            flag_p2   <= (state_d == ST_FLAG) && who_d;
            seg1      <= seg_d[0];
            seg2      <= seg_d[1];
            seg3      <= seg_d[2];
            seg4      <= seg_d[3];
            seg5      <= seg_d[4];
            seg6      <= seg_d[5];
            seg7      <= seg_d[6];
            seg8      <= seg_d[7];
        end
    end

    // Next state: NEW beats expiry, expiry beats turn switch, turn switch beats START.
    always_comb begin
        state_d  = state_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        cnt_d    = cnt_q;
        who_d    = who_q;
        bcnt_d   = '0;
        phase_d  = 1'b0;
        expired  = 1'b0;
        run_t    = (state_q == ST_RUN2) ? t2_q : t1_q;
        dec_t    = bcd_dec(run_t);
        new_t    = run_t;
        turn_btn = (state_q == ST_RUN2) ? BTN_P2 : BTN_P1;

        if (BTN_NEW) begin
            state_d = ST_READY;
            t1_d    = INIT_TIME;
            t2_d    = INIT_TIME;
            cnt_d   = '0;
            who_d   = 1'b0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (BTN_START) state_d = ST_RUN1;
                end
                ST_RUN1, ST_RUN2: begin
                    if (CE) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            new_t = dec_t;
                            if (dec_t == 16'h0000) begin
                                expired = 1'b1;
                                state_d = ST_FLAG;
                                who_d   = (state_q == ST_RUN2);
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    if (!expired) begin
                        if (turn_btn) begin
                            new_t   = bcd_inc(new_t);
                            cnt_d   = '0;
                            state_d = (state_q == ST_RUN1) ? ST_RUN2 : ST_RUN1;
                        end else if (BTN_START) begin
                            state_d = (state_q == ST_RUN1) ? ST_PAUSE1 : ST_PAUSE2;
                        end
                    end
                    if (state_q == ST_RUN2) t2_d = new_t;
                    else                    t1_d = new_t;
                end
                ST_PAUSE1: begin
                    if (BTN_START) state_d = ST_RUN1;
                end
                ST_PAUSE2: begin
                    if (BTN_START) state_d = ST_RUN2;
                end
                ST_FLAG: begin
                    bcnt_d  = bcnt_q;
                    phase_d = phase_q;
                    if (CE) begin
                        if (bcnt_q == BLINK_LAST) begin
                            bcnt_d  = '0;
                            phase_d = !phase_q;
                        end else begin
                            bcnt_d = bcnt_q + BW'(1);
                        end
                    end
                end
                default: state_d = ST_READY;
            endcase
        end
    end

    // Digit decode; the flagged player's digits blank during the odd blink phase.
    always_comb begin
        blank1   = (state_q == ST_FLAG) && !who_q && phase_q;
        blank2   = (state_q == ST_FLAG) && who_q && phase_q;
        seg_d[0] = blank1 ? SEG_BLANK : seg_code(t1_q[15:12]);
        seg_d[1] = blank1 ? SEG_BLANK : seg_code(t1_q[11:8]);
        seg_d[2] = blank1 ? SEG_BLANK : seg_code(t1_q[7:4]);
        seg_d[3] = blank1 ? SEG_BLANK : seg_code(t1_q[3:0]);
        seg_d[4] = blank2 ? SEG_BLANK : seg_code(t2_q[15:12]);
        seg_d[5] = blank2 ? SEG_BLANK : seg_code(t2_q[11:8]);
        seg_d[6] = blank2 ? SEG_BLANK : seg_code(t2_q[7:4]);
        seg_d[7] = blank2 ? SEG_BLANK : seg_code(t2_q[3:0]);
    end

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Randomised and directed bench for chess_clock_ctrl against a seconds-based
// behavioural model of the game rules.
module tb_chess_clock_ctrl;

    localparam int unsigned TPS  = 4;
    localparam int unsigned IMIN = 5;
    localparam int unsigned INC  = 3;
    localparam int          MAXS = 99 * 60 + 59;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       CE = 1'b0, BTN_P1 = 1'b0, BTN_P2 = 1'b0, BTN_START = 1'b0, BTN_NEW = 1'b0;
    logic [6:0] seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8;
    logic       active_p1, active_p2, paused, flag_p1, flag_p2;

    chess_clock_ctrl #(.TICKS_PER_SEC(TPS), .INIT_MIN(IMIN), .INC_SEC(INC)) dut (
        .CLK(CLK), .CLR(CLR), .CE(CE),
        .BTN_P1(BTN_P1), .BTN_P2(BTN_P2), .BTN_START(BTN_START), .BTN_NEW(BTN_NEW),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .seg5(seg5), .seg6(seg6), .seg7(seg7), .seg8(seg8),
        .active_p1(active_p1), .active_p2(active_p2), .paused(paused),
        .flag_p1(flag_p1), .flag_p2(flag_p2)
    );

    always #5 CLK = ~CLK;

    typedef enum int {M_READY, M_RUN, M_PAUSE, M_FLAG} mode_t;

    mode_t       mode;
    int          p_sec [2];
    int          act, sub, fce;
    logic [55:0] exp_segs;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] digits(input int sec, input bit blank);
        int m, s;
        if (blank) return {28{1'b1}};
        m = sec / 60;
        s = sec % 60;
        return {code(m / 10), code(m % 10), code(s / 10), code(s % 10)};
    endfunction

    function automatic logic [55:0] disp();
        bit ph;
        ph = (mode == M_FLAG) && (((fce / (TPS / 2)) % 2) == 1);
        return {digits(p_sec[0], ph && act == 0), digits(p_sec[1], ph && act == 1)};
    endfunction

    function automatic logic [4:0] exp_status();
        return {mode == M_RUN && act == 0, mode == M_RUN && act == 1, mode == M_PAUSE,
                mode == M_FLAG && act == 0, mode == M_FLAG && act == 1};
    endfunction

    task automatic model_reset();
        mode     = M_READY;
        p_sec[0] = IMIN * 60;
        p_sec[1] = IMIN * 60;
        act      = 0;
        sub      = 0;
        fce      = 0;
    endtask

    task automatic model_step(input bit b1, input bit b2, input bit bs, input bit bn, input bit ce);
        bit expd;
        if (bn) begin
            model_reset();
            return;
        end
        case (mode)
            M_READY: if (bs) begin mode = M_RUN; act = 0; end
            M_RUN: begin
                expd = 0;
                if (ce) begin
                    sub++;
                    if (sub == TPS) begin
                        sub = 0;
                        p_sec[act]--;
                        if (p_sec[act] == 0) begin
                            mode = M_FLAG;
                            fce  = 0;
                            expd = 1;
                        end
                    end
                end
                if (!expd) begin
                    if ((act == 0 && b1) || (act == 1 && b2)) begin
                        p_sec[act] = (p_sec[act] + INC > MAXS) ? MAXS : p_sec[act] + INC;
                        sub = 0;
                        act = 1 - act;
                    end else if (bs) begin
                        mode = M_PAUSE;
                    end
                end
            end
            M_PAUSE: if (bs) mode = M_RUN;
            M_FLAG:  if (ce) fce++;
            default: ;
        endcase
    endtask

    // One clock with the given inputs; every output is checked against the model.
    task automatic cyc(input bit b1, input bit b2, input bit bs, input bit bn, input bit ce);
        BTN_P1 = b1; BTN_P2 = b2; BTN_START = bs; BTN_NEW = bn; CE = ce;
        exp_segs = disp();
        model_step(b1, b2, bs, bn, ce);
        @(posedge CLK);
        #1;
        BTN_P1 = 0; BTN_P2 = 0; BTN_START = 0; BTN_NEW = 0; CE = 0;
        check("segs", 64'({seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8}), 64'(exp_segs));
        check("status", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'(exp_status()));
    endtask

    task automatic ces(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
    endtask

    // Drive turns and countdown until P1 is running with exactly `target` seconds.
    task automatic steer(input int target);
        int i;
        for (i = 0; i < 20000; i++) begin
            if (mode == M_RUN && act == 0 && p_sec[0] == target) break;
            if (mode == M_RUN && act == 1)  cyc(0, 1, 0, 0, 0);
            else if (p_sec[0] > target)     cyc(0, 0, 0, 0, 1);
            else                            cyc(1, 0, 0, 0, 0);
        end
        check("steer_reached", 64'(i < 20000), 64'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_segs", 64'({seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8}), 64'({56{1'b1}}));
        check("reset_status", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'd0);
        CLR = 1'b1;

        // Idle in READY: CE must not count, P buttons ignored.
        ces(20);
        cyc(1, 1, 0, 0, 1);
        check("ready_p1", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}));
        check("ready_status", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'd0);

        // Start and count one second off P1.
        cyc(0, 0, 1, 0, 0);
        ces(4);
        cyc(0, 0, 0, 0, 0);
        check("run1_p1", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b1000000, 7'b0011001, 7'b0010010, 7'b0010000}));
        check("run1_p2", 64'({seg5, seg6, seg7, seg8}),
              64'({7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}));
        check("run1_active", 64'(active_p1), 64'd1);

        // Turn switch with increment.
        cyc(1, 0, 0, 0, 0);
        check("switch_active_p2", 64'(active_p2), 64'd1);
        cyc(0, 0, 0, 0, 0);
        check("inc_p1", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b1000000, 7'b0010010, 7'b1000000, 7'b0100100}));
        ces(3);
        cyc(0, 0, 0, 0, 0);
        check("cnt_cleared", 64'({seg5, seg6, seg7, seg8}),
              64'({7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}));

        // Borrow from m10.
        steer(600);
        ces(4);
        cyc(0, 0, 0, 0, 0);
        check("borrow_0959", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b1000000, 7'b0010000, 7'b0010010, 7'b0010000}));

        // Saturation at 99:59.
        steer(MAXS - 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("saturate", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b0010000, 7'b0010000, 7'b0010010, 7'b0010000}));

        // P2 runs out of time.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ces(299 * TPS);
        cyc(0, 0, 0, 0, 0);
        check("p2_0001", 64'({seg5, seg6, seg7, seg8}),
              64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001}));
        ces(4);
        check("flag_status", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'b00001);
        ces(2);
        cyc(0, 0, 0, 0, 0);
        check("blink_off", 64'({seg5, seg6, seg7, seg8}), 64'({28{1'b1}}));
        ces(2);
        cyc(0, 0, 0, 0, 0);
        check("blink_on", 64'({seg5, seg6, seg7, seg8}),
              64'({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}));
        cyc(1, 0, 1, 0, 1);
        check("flag_hold", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'b00001);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("new_game", 64'({seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8}),
              64'({2{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}}));

        // Pause holds the sub-second counter.
        cyc(0, 0, 1, 0, 0);
        ces(2);
        cyc(0, 0, 1, 0, 0);
        check("paused", 64'(paused), 64'd1);
        ces(10);
        cyc(0, 0, 1, 0, 0);
        ces(2);
        cyc(0, 0, 0, 0, 0);
        check("pause_1s", 64'({seg1, seg2, seg3, seg4}),
              64'({7'b1000000, 7'b0011001, 7'b0010010, 7'b0010000}));

        // Asynchronous reset mid-RUN2.
        cyc(1, 0, 0, 0, 0);
        ces(3);
        CLR = 1'b0;
        #2;
        check("async_segs", 64'({seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8}), 64'({56{1'b1}}));
        check("async_status", 64'({active_p1, active_p2, paused, flag_p1, flag_p2}), 64'd0);
        model_reset();
        @(posedge CLK);
        #1 CLR = 1'b1;

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 4, $urandom_range(0, 999) < 5,
                $urandom_range(0, 99) < 60);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
